// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: mult/div scheduler states, default latencies,
// and the exception handler address that the PC register loads on a flush.
package pipe_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W_DEF       = 4;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/md_sched.sv
// Countdown scheduler for the multi-cycle mult/div unit: gates the start,
// then holds busy for exactly the op's latency and pulses done in its last cycle.
module md_sched
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic e_md_start_i,
   input  logic e_md_is_div_i,
   input  logic exc_req_i,
   output logic md_start_o,
   output logic md_busy_o,
   output logic md_done_o
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Outputs are forced quiet while rst is held, even if the old state was BUSY.
   assign md_busy_o  = (state_q == BUSY) & ~rst;
   assign md_done_o  = md_busy_o & (cnt_q == CNT_W'(1));
   assign md_start_o = e_md_start_i & ~md_busy_o & ~exc_req_i & ~rst;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (md_start_o) begin
               state_d = BUSY;
               cnt_d   = e_md_is_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end
         end
         BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: resolves exception > stall > run into stage enables.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic hz_load_use,
   input  logic D_is_md,
   input  logic E_md_start,
   input  logic E_md_is_div,
   input  logic exc_req,
   output logic F_WE,
   output logic D_WE,
   output logic E_WE,
   output logic M_WE,
   output logic W_WE,
   output logic E_clr,
   output logic req,
   output logic md_start,
   output logic md_busy,
   output logic md_done
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] perf_stall_cyc,
   output logic [31:0] perf_md_stall_cyc,
   output logic [31:0] perf_flush_cnt
`endif
);

   logic stall;

   md_sched #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES),
      .CNT_W      (CNT_W)
   ) u_md_sched (
      .clk          (clk),
      .rst          (rst),
      .e_md_start_i (E_md_start),
      .e_md_is_div_i(E_md_is_div),
      .exc_req_i    (exc_req),
      .md_start_o   (md_start),
      .md_busy_o    (md_busy),
      .md_done_o    (md_done)
   );

   // A D-stage HI/LO user waits while the unit is busy or about to be started from E.
   assign stall = hz_load_use | (D_is_md & (md_busy | E_md_start));

   always_comb begin
      F_WE  = 1'b1;
      D_WE  = 1'b1;
      E_WE  = 1'b1;
      M_WE  = 1'b1;
      W_WE  = 1'b1;
      E_clr = 1'b0;
      req   = 1'b0;
      if (!rst) begin
         if (exc_req) begin
            req = 1'b1;
         end else if (stall) begin
            F_WE  = 1'b0;
            D_WE  = 1'b0;
            E_clr = 1'b1;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_md_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q    <= '0;
         perf_md_stall_q <= '0;
         perf_flush_q    <= '0;
      end else begin
         if (stall && !exc_req)                 perf_stall_q    <= perf_stall_q + 32'd1;
         if (stall && !exc_req && !hz_load_use) perf_md_stall_q <= perf_md_stall_q + 32'd1;
         if (req)                               perf_flush_q    <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cyc    = perf_stall_q;
   assign perf_md_stall_cyc = perf_md_stall_q;
   assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule
